// File: rtl/draw_background_ext.sv
`default_nettype none
// ============================================================================
// draw_background_ext
//   Background colour generator with a VGA timing delay line (LATENCY stages),
//   borders, per-frame fill patterns and a frame counter. The optional dashed
//   centre net is enabled by defining DRAW_BACKGROUND_NET_EN.
//   Revision: 1.0
// ============================================================================
module draw_background_ext #(
  parameter int          H_ACTIVE      = 1024,
  parameter int          V_ACTIVE      = 768,
  parameter int          BORDER_W      = 1,
  parameter int          LATENCY       = 1,
  parameter int          FRAME_W       = 6,
  parameter int          BLINK_BIT     = 5,
  parameter logic [11:0] BLANK_RGB     = 12'h333,
  parameter logic [11:0] FILL_RGB      = 12'h000,
  parameter logic [11:0] ALT_RGB       = 12'h222,
  parameter int          NET_W         = 4,
  parameter int          NET_DASH_LOG2 = 4
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic [10:0]        vcount_in,
  input  logic [10:0]        hcount_in,
  input  logic               vsync_in,
  input  logic               vblnk_in,
  input  logic               hsync_in,
  input  logic               hblnk_in,
  input  logic [1:0]         mode_in,
  output logic [10:0]        vcount_out,
  output logic [10:0]        hcount_out,
  output logic               vsync_out,
  output logic               hsync_out,
  output logic               vblnk_out,
  output logic               hblnk_out,
  output logic [11:0]        rgb_out,
  output logic [FRAME_W-1:0] frame_cnt_out
);

  localparam int          PIPE_W  = 11 + 11 + 4 + 12;
  localparam logic [10:0] BORDER  = 11'(BORDER_W);
  localparam logic [10:0] V_LIMIT = 11'(V_ACTIVE - BORDER_W);
  localparam logic [10:0] H_LIMIT = 11'(H_ACTIVE - BORDER_W);

  if (BORDER_W < 1 || BORDER_W > 16) begin : g_bad_border
    $error("draw_background_ext: BORDER_W must be 1..16");
  end
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("draw_background_ext: LATENCY must be 1..4");
  end
  if (BLINK_BIT >= FRAME_W) begin : g_bad_blink
    $error("draw_background_ext: BLINK_BIT must be below FRAME_W");
  end
  if (NET_W < 1 || NET_DASH_LOG2 < 1) begin : g_bad_net
    $error("draw_background_ext: NET_W and NET_DASH_LOG2 must be positive");
  end

  logic [1:0]         mode_q;
  logic [FRAME_W-1:0] frame_cnt;
  logic               vsync_d;
  logic               frame_start;
  logic               net_pix;
  logic [11:0]        rgb_next;
  logic [PIPE_W-1:0]  pipe_q [LATENCY];

  assign frame_start = vsync_in & ~vsync_d;

`ifdef DRAW_BACKGROUND_NET_EN
  localparam logic [10:0] NET_LO = 11'(H_ACTIVE / 2 - NET_W / 2);
  localparam logic [10:0] NET_HI = 11'(H_ACTIVE / 2 + NET_W / 2 - 1);

  // Dash is drawn on the first half of each 2^NET_DASH_LOG2-line period.
  assign net_pix = (hcount_in >= NET_LO) && (hcount_in <= NET_HI) &&
                   !vcount_in[NET_DASH_LOG2-1];
`else
  assign net_pix = 1'b0;
`endif

  always_comb begin
    rgb_next = FILL_RGB;
    if (vblnk_in || hblnk_in)      rgb_next = BLANK_RGB;
    else if (vcount_in < BORDER)   rgb_next = 12'h00f;
    else if (vcount_in >= V_LIMIT) rgb_next = 12'hf0f;
    else if (hcount_in < BORDER)   rgb_next = 12'h0f0;
    else if (hcount_in >= H_LIMIT) rgb_next = 12'hf00;
    else if (net_pix)              rgb_next = 12'hfff;
    else begin
      unique case (mode_q)
        2'd0: rgb_next = FILL_RGB;
        2'd1: rgb_next = vcount_in[4] ? ALT_RGB : FILL_RGB;
        2'd2: rgb_next = (hcount_in[5] ^ vcount_in[5]) ? ALT_RGB : FILL_RGB;
        2'd3: rgb_next = frame_cnt[BLINK_BIT] ? ALT_RGB : FILL_RGB;
        default: rgb_next = FILL_RGB;
      endcase
    end
  end

  // The frame-start pixel is coloured with the old mode_q/frame_cnt above;
  // the new values take effect from the following pixel.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 2'd0;
      frame_cnt <= '0;
      vsync_d   <= 1'b0;
    end else begin
      vsync_d <= vsync_in;
      if (frame_start) begin
        mode_q    <= mode_in;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {vcount_in, hcount_in, vsync_in, hsync_in,
                    vblnk_in, hblnk_in, rgb_next};
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign {vcount_out, hcount_out, vsync_out, hsync_out,
          vblnk_out, hblnk_out, rgb_out} = pipe_q[LATENCY-1];
  assign frame_cnt_out = frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_draw_background_ext.sv
`default_nettype none
// ============================================================================
// tb_draw_background_ext
//   Table vectors, hand-written multi-cycle sequences and a randomized stream
//   checked against a queue-based reference model of the background generator.
//   Revision: 1.0
// ============================================================================
module tb_draw_background_ext;

  localparam int          H   = 1024;
  localparam int          V   = 768;
  localparam int          BW  = 3;
  localparam int          LAT = 3;
  localparam int          FW  = 6;
  localparam int          BB  = 5;
  localparam int          NW  = 4;
  localparam int          ND  = 4;
  localparam logic [11:0] C_BLANK = 12'h333;
  localparam logic [11:0] C_FILL  = 12'h000;
  localparam logic [11:0] C_ALT   = 12'h222;
`ifdef DRAW_BACKGROUND_NET_EN
  localparam logic [11:0] C_NET   = 12'hfff;
`else
  localparam logic [11:0] C_NET   = 12'h000;
`endif

  typedef struct packed {
    logic [10:0] v;
    logic [10:0] h;
    logic        vs;
    logic        hs;
    logic        vb;
    logic        hb;
    logic [11:0] rgb;
  } pix_t;

  typedef struct {
    int          h;
    int          v;
    bit          vb;
    bit          hb;
    logic [11:0] exp;
  } vec_t;

  logic          pclk = 1'b0;
  logic          rst_n = 1'b1;
  logic [10:0]   vcount_in = '0, hcount_in = '0;
  logic          vsync_in = 1'b0, vblnk_in = 1'b0, hsync_in = 1'b0, hblnk_in = 1'b0;
  logic [1:0]    mode_in = 2'd0;
  logic [10:0]   vcount_out, hcount_out;
  logic          vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic [11:0]   rgb_out;
  logic [FW-1:0] frame_cnt_out;

  bit clk_run = 1'b1;
  int total = 0;
  int bad = 0;

  draw_background_ext #(
    .H_ACTIVE(H), .V_ACTIVE(V), .BORDER_W(BW), .LATENCY(LAT),
    .FRAME_W(FW), .BLINK_BIT(BB), .BLANK_RGB(C_BLANK), .FILL_RGB(C_FILL),
    .ALT_RGB(C_ALT), .NET_W(NW), .NET_DASH_LOG2(ND)
  ) dut (
    .pclk(pclk), .rst_n(rst_n),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .mode_in(mode_in),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out),
    .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out), .frame_cnt_out(frame_cnt_out)
  );

  initial forever begin
    #5;
    if (clk_run) pclk = ~pclk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Colour rules written as plain arithmetic on integer counts.
  function automatic logic [11:0] ref_rgb(int h, int v, bit vb, bit hb, int mode, int fc);
    if (vb || hb) return C_BLANK;
    if (v < BW) return 12'h00f;
    if (v >= V - BW) return 12'hf0f;
    if (h < BW) return 12'h0f0;
    if (h >= H - BW) return 12'hf00;
`ifdef DRAW_BACKGROUND_NET_EN
    if (h >= H / 2 - NW / 2 && h <= H / 2 + NW / 2 - 1 && ((v / (2 ** (ND - 1))) % 2) == 0)
      return 12'hfff;
`endif
    case (mode)
      1:       return ((v / 16) % 2 != 0) ? C_ALT : C_FILL;
      2:       return (((h / 32) + (v / 32)) % 2 != 0) ? C_ALT : C_FILL;
      3:       return ((fc / (2 ** BB)) % 2 != 0) ? C_ALT : C_FILL;
      default: return C_FILL;
    endcase
  endfunction

  // Reference model: expected outputs queue of depth LAT.
  pix_t q[$];
  pix_t m_e;
  int   m_mode = 0;
  int   m_fc = 0;
  bit   m_vprev = 1'b0;

  initial repeat (LAT) q.push_back('0);

  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      repeat (LAT) q.push_back('0);
      m_mode  = 0;
      m_fc    = 0;
      m_vprev = 1'b0;
    end else begin
      m_e = '{v: vcount_in, h: hcount_in, vs: vsync_in, hs: hsync_in,
              vb: vblnk_in, hb: hblnk_in,
              rgb: ref_rgb(int'(hcount_in), int'(vcount_in), vblnk_in, hblnk_in, m_mode, m_fc)};
      q.push_back(m_e);
      void'(q.pop_front());
      if (vsync_in && !m_vprev) begin
        m_mode = int'(mode_in);
        m_fc   = (m_fc + 1) % (2 ** FW);
      end
      m_vprev = vsync_in;
    end
  end

  always @(negedge pclk) begin
    check("pipe", 64'({vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out, rgb_out}),
          64'(q[0]));
    check("frame_cnt", 64'(frame_cnt_out), 64'(m_fc));
  end

  task automatic drive(input int h, input int v, input bit vs, input bit hs,
                       input bit vb, input bit hb, input int mode);
    @(posedge pclk);
    #2;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    vsync_in  = vs;
    hsync_in  = hs;
    vblnk_in  = vb;
    hblnk_in  = hb;
    mode_in   = 2'(mode);
  endtask

  task automatic after_lat();
    repeat (LAT) @(posedge pclk);
    #1;
  endtask

  function automatic int rnd_count(int lim);
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 2047));
      1:       return int'($urandom_range(0, 5));
      2:       return int'($urandom_range(lim - 6, lim + 2));
      default: return int'($urandom_range(500, 520));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    int   first;

    tbl = '{
      '{2, 100, 0, 0, 12'h0f0},    '{1021, 100, 0, 0, 12'hf00},
      '{0, 0, 0, 0, 12'h00f},      '{0, 765, 0, 0, 12'hf0f},
      '{500, 300, 0, 0, 12'h000},  '{500, 300, 0, 1, 12'h333},
      '{500, 300, 1, 0, 12'h333},  '{3, 3, 0, 0, 12'h000},
      '{1020, 764, 0, 0, 12'h000}, '{1021, 0, 0, 0, 12'h00f},
      '{2047, 2047, 0, 0, 12'hf0f},'{510, 20, 0, 0, C_NET},
      '{513, 20, 0, 0, C_NET},     '{510, 24, 0, 0, 12'h000},
      '{514, 20, 0, 0, 12'h000},   '{509, 20, 0, 0, 12'h000}
    };

    #1 rst_n = 1'b0;
    repeat (3) @(posedge pclk);
    #2 rst_n = 1'b1;

    // Mid-line traffic, then asynchronous reset with the clock stopped.
    for (int i = 0; i < 10; i++) drive(200 + i, 50, 0, i % 2, 0, 0, 0);
    @(posedge pclk);
    #2 clk_run = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_out", 64'({vcount_out, hcount_out, vsync_out, hsync_out,
                                  vblnk_out, hblnk_out, rgb_out}), 64'd0);
    check("async_reset_fc", 64'(frame_cnt_out), 64'd0);
    hcount_in = 11'd500; vcount_in = 11'd300; vsync_in = 1'b1; hblnk_in = 1'b1;
    #20 clk_run = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check("reset_hold_rgb", 64'(rgb_out), 64'd0);
    #1 rst_n = 1'b1;
    first = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge pclk);
      #1;
      if (k == 1) check("vsync_high_at_release", 64'(frame_cnt_out), 64'd1);
      if (rgb_out != 12'h000 && first < 0) first = k;
    end
    check("reset_latency", 64'(first), 64'(LAT));

    // Border/blank/net table in mode 0.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].h, tbl[i].v, 0, 0, tbl[i].vb, tbl[i].hb, 0);
      after_lat();
      check($sformatf("tbl%0d", i), 64'(rgb_out), 64'(tbl[i].exp));
    end

    // Mode request mid-frame is held off until the next vsync rising edge.
    drive(32, 3, 0, 0, 0, 0, 2);
    after_lat();
    check("latch_midframe", 64'(rgb_out), 64'(C_FILL));
    drive(32, 3, 1, 0, 0, 0, 2);
    after_lat();
    check("latch_edge_pixel", 64'(rgb_out), 64'(C_FILL));
    @(posedge pclk);
    #1;
    check("latch_next_pixel", 64'(rgb_out), 64'(C_ALT));
    drive(32, 32, 1, 0, 0, 0, 0);
    after_lat();
    check("latch_checker_off", 64'(rgb_out), 64'(C_FILL));
    drive(32, 3, 0, 0, 0, 0, 0);
    after_lat();
    check("latch_hold_mode", 64'(rgb_out), 64'(C_ALT));

    // Blink mode over 70 frames from a fresh reset.
    drive(100, 100, 0, 0, 0, 0, 3);
    #1 rst_n = 1'b0;
    @(posedge pclk);
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      drive(100, 100, 1, 0, 0, 0, 3);
      drive(100, 100, 0, 0, 0, 0, 3);
      after_lat();
      check($sformatf("blink_f%0d", i % 64), 64'(rgb_out),
            64'(((i % 64) >= 32) ? C_ALT : C_FILL));
      check($sformatf("frame_cnt_f%0d", i), 64'(frame_cnt_out), 64'(i % 64));
    end

    // Randomized stream; the reference model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      drive(rnd_count(H), rnd_count(V),
            ($urandom_range(0, 19) == 0) ? ~vsync_in : vsync_in,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 3)));
    end
    repeat (LAT + 1) @(posedge pclk);
    @(negedge pclk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
